// File: rtl/spread_tracker_if.sv
// Match/clear request bundle and result record for spread_tracker.
// Handshake: every request (match_valid, clear_valid) and the result record
// (out_valid) are valid-only with no backpressure. A request is taken on the
// rising edge where its valid is high. out_valid is a one-cycle pulse.
interface spread_tracker_if #(
  parameter int PRICE_W = 8,
  parameter int CH_W    = 2
);
  logic               enable_count;
  logic               match_valid;
  logic [CH_W-1:0]    match_ch;
  logic [PRICE_W-1:0] buy_price;
  logic [PRICE_W-1:0] sell_price;
  logic               clear_valid;
  logic [CH_W-1:0]    clear_ch;

  logic               out_valid;
  logic [CH_W-1:0]    out_ch;
  logic [PRICE_W:0]   out_spread;
  logic               out_crossed;
  logic [PRICE_W:0]   out_min;
  logic [PRICE_W:0]   out_max;
  logic [PRICE_W:0]   out_avg;
  logic               out_full;

  modport master (
    output enable_count, match_valid, match_ch, buy_price, sell_price,
           clear_valid, clear_ch,
    input  out_valid, out_ch, out_spread, out_crossed, out_min, out_max,
           out_avg, out_full
  );

  modport slave (
    input  enable_count, match_valid, match_ch, buy_price, sell_price,
           clear_valid, clear_ch,
    output out_valid, out_ch, out_spread, out_crossed, out_min, out_max,
           out_avg, out_full
  );
endinterface

// File: rtl/spread_tracker.sv
// Per-channel spread statistics: signed spread, lifetime min/max since clear
// and a sliding-window average. Two-stage pipeline, one match per cycle.
module spread_tracker #(
  parameter int PRICE_W  = 8,
  parameter int CH       = 4,
  parameter int CH_W     = 2,
  parameter int WIN_LOG2 = 3
) (
  input  logic              clk,
  input  logic              reset,
  spread_tracker_if.slave   bus
);
  localparam int SW    = PRICE_W + 1;
  localparam int SUM_W = SW + WIN_LOG2;
  localparam int DEPTH = 1 << WIN_LOG2;
  localparam logic [WIN_LOG2:0] DEPTH_C = (WIN_LOG2 + 1)'(DEPTH);

  typedef logic signed [SW-1:0]    spread_t;
  typedef logic signed [SUM_W-1:0] sum_t;

  // Stage 1 registers
  logic            s1_valid;
  logic [CH_W-1:0] s1_ch;
  spread_t         s1_spread;

  // Per-channel state
  spread_t               buf_mem  [CH][DEPTH];
  logic [WIN_LOG2-1:0]   wr_ptr   [CH];
  logic [WIN_LOG2:0]     fill_cnt [CH];
  sum_t                  sum_r    [CH];
  spread_t               min_r    [CH];
  spread_t               max_r    [CH];
  logic                  empty_r  [CH];

  // Stage 2 combinational view of the selected channel
  logic                clr_hit;
  logic [WIN_LOG2-1:0] cur_ptr;
  logic [WIN_LOG2-1:0] nxt_ptr;
  logic [WIN_LOG2:0]   cur_cnt;
  logic [WIN_LOG2:0]   nxt_cnt;
  sum_t                cur_sum;
  sum_t                nxt_sum;
  sum_t                new_ext;
  sum_t                old_ext;
  logic                cur_empty;
  logic                is_full;
  spread_t             evicted;
  spread_t             nxt_min;
  spread_t             nxt_max;
  spread_t             nxt_avg;

  // Stage 1: accept the match and form the spread from zero-extended prices
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid  <= 1'b0;
      s1_ch     <= '0;
      s1_spread <= '0;
    end else begin
      s1_valid <= bus.match_valid && bus.enable_count;
      if (bus.match_valid && bus.enable_count) begin
        s1_ch     <= bus.match_ch;
        s1_spread <= $signed({1'b0, bus.buy_price}) - $signed({1'b0, bus.sell_price});
      end
    end
  end

  // Stage 2 next-state: a same-edge clear of this channel is applied before insertion
  always_comb begin
    clr_hit   = bus.clear_valid && (bus.clear_ch == s1_ch);
    cur_ptr   = clr_hit ? '0 : wr_ptr[s1_ch];
    cur_cnt   = clr_hit ? '0 : fill_cnt[s1_ch];
    cur_sum   = clr_hit ? '0 : sum_r[s1_ch];
    cur_empty = clr_hit ? 1'b1 : empty_r[s1_ch];
    is_full   = (cur_cnt == DEPTH_C);
    evicted   = buf_mem[s1_ch][cur_ptr];
    new_ext   = {{WIN_LOG2{s1_spread[SW-1]}}, s1_spread};
    old_ext   = is_full ? {{WIN_LOG2{evicted[SW-1]}}, evicted} : '0;
    nxt_sum   = cur_sum + new_ext - old_ext;
    nxt_cnt   = is_full ? cur_cnt : cur_cnt + 1'b1;
    nxt_ptr   = cur_ptr + 1'b1;
    nxt_min   = (cur_empty || (s1_spread < min_r[s1_ch])) ? s1_spread : min_r[s1_ch];
    nxt_max   = (cur_empty || (s1_spread > max_r[s1_ch])) ? s1_spread : max_r[s1_ch];
    nxt_avg   = spread_t'(nxt_sum >>> WIN_LOG2);
  end

  // Channel bookkeeping: update on stage 2, otherwise honour a standalone clear
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < CH; i++) begin
        wr_ptr[i]   <= '0;
        fill_cnt[i] <= '0;
        sum_r[i]    <= '0;
        min_r[i]    <= '0;
        max_r[i]    <= '0;
        empty_r[i]  <= 1'b1;
      end
    end else begin
      for (int i = 0; i < CH; i++) begin
        if (s1_valid && (s1_ch == CH_W'(i))) begin
          wr_ptr[i]   <= nxt_ptr;
          fill_cnt[i] <= nxt_cnt;
          sum_r[i]    <= nxt_sum;
          min_r[i]    <= nxt_min;
          max_r[i]    <= nxt_max;
          empty_r[i]  <= 1'b0;
        end else if (bus.clear_valid && (bus.clear_ch == CH_W'(i))) begin
          wr_ptr[i]   <= '0;
          fill_cnt[i] <= '0;
          sum_r[i]    <= '0;
          empty_r[i]  <= 1'b1;
        end
      end
    end
  end

  // Sample buffer: contents only matter once counted, so it carries no reset
  always_ff @(posedge clk) begin
    if (s1_valid) begin
      buf_mem[s1_ch][cur_ptr] <= s1_spread;
    end
  end

  // Result record: registered on stage 2, held while out_valid is low
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.out_valid   <= 1'b0;
      bus.out_ch      <= '0;
      bus.out_spread  <= '0;
      bus.out_crossed <= 1'b0;
      bus.out_min     <= '0;
      bus.out_max     <= '0;
      bus.out_avg     <= '0;
      bus.out_full    <= 1'b0;
    end else begin
      bus.out_valid <= s1_valid;
      if (s1_valid) begin
        bus.out_ch      <= s1_ch;
        bus.out_spread  <= s1_spread;
        bus.out_crossed <= s1_spread[SW-1];
        bus.out_min     <= nxt_min;
        bus.out_max     <= nxt_max;
        bus.out_avg     <= nxt_avg;
        bus.out_full    <= (nxt_cnt == DEPTH_C);
      end
    end
  end
endmodule

// File: tb/tb_spread_tracker.sv
// Bench for spread_tracker: directed vector table, reset-in-flight sequence,
// and randomized traffic against a window/queue reference model.
module tb_spread_tracker;
  localparam int PRICE_W  = 8;
  localparam int CH       = 4;
  localparam int CH_W     = 2;
  localparam int WIN_LOG2 = 3;
  localparam int DEPTH    = 1 << WIN_LOG2;

  typedef struct packed {
    logic [CH_W-1:0]  ch;
    logic [PRICE_W:0] sp;
    logic             cr;
    logic [PRICE_W:0] mn;
    logic [PRICE_W:0] mx;
    logic [PRICE_W:0] avg;
    logic             full;
  } rec_t;
  localparam int REC_W = $bits(rec_t);

  typedef struct {
    logic               en;
    logic               mv;
    logic [CH_W-1:0]    ch;
    logic [PRICE_W-1:0] buy;
    logic [PRICE_W-1:0] sell;
    logic               cv;
    logic [CH_W-1:0]    cc;
    logic               ev;
    rec_t               e;
  } vec_t;

  logic clk;
  logic reset;
  int   checks;
  int   errors;
  vec_t tbl[$];
  logic [REC_W-1:0] exp_q[$];

  // Reference model state
  int win_q[CH][$];
  int mdl_min[CH];
  int mdl_max[CH];
  bit mdl_empty[CH];

  spread_tracker_if #(.PRICE_W(PRICE_W), .CH_W(CH_W)) bus ();

  spread_tracker #(
    .PRICE_W(PRICE_W), .CH(CH), .CH_W(CH_W), .WIN_LOG2(WIN_LOG2)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic rec_t mk(input int ch, input int sp, input int mn, input int mx,
                              input int avg, input bit full);
    rec_t r;
    r.ch   = ch[CH_W-1:0];
    r.sp   = sp[PRICE_W:0];
    r.cr   = (sp < 0);
    r.mn   = mn[PRICE_W:0];
    r.mx   = mx[PRICE_W:0];
    r.avg  = avg[PRICE_W:0];
    r.full = full;
    return r;
  endfunction

  task automatic check_rec(input string tag, input rec_t e);
    chk({tag, ".valid"}, int'(bus.out_valid), 1);
    if (bus.out_valid) begin
      chk({tag, ".ch"},      int'(bus.out_ch), int'(e.ch));
      chk({tag, ".spread"},  int'($signed(bus.out_spread)), int'($signed(e.sp)));
      chk({tag, ".crossed"}, int'(bus.out_crossed), int'(e.cr));
      chk({tag, ".min"},     int'($signed(bus.out_min)), int'($signed(e.mn)));
      chk({tag, ".max"},     int'($signed(bus.out_max)), int'($signed(e.mx)));
      chk({tag, ".avg"},     int'($signed(bus.out_avg)), int'($signed(e.avg)));
      chk({tag, ".full"},    int'(bus.out_full), int'(e.full));
    end
  endtask

  task automatic check_zero(input string tag);
    chk({tag, ".valid"},   int'(bus.out_valid), 0);
    chk({tag, ".ch"},      int'(bus.out_ch), 0);
    chk({tag, ".spread"},  int'(bus.out_spread), 0);
    chk({tag, ".crossed"}, int'(bus.out_crossed), 0);
    chk({tag, ".min"},     int'(bus.out_min), 0);
    chk({tag, ".max"},     int'(bus.out_max), 0);
    chk({tag, ".avg"},     int'(bus.out_avg), 0);
    chk({tag, ".full"},    int'(bus.out_full), 0);
  endtask

  // Driver tasks
  task automatic drive(input logic en, input logic mv, input int ch, input int buy,
                       input int sell, input logic cv, input int cc);
    bus.enable_count = en;
    bus.match_valid  = mv;
    bus.match_ch     = ch[CH_W-1:0];
    bus.buy_price    = buy[PRICE_W-1:0];
    bus.sell_price   = sell[PRICE_W-1:0];
    bus.clear_valid  = cv;
    bus.clear_ch     = cc[CH_W-1:0];
  endtask

  task automatic apply_reset();
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic add_row(input logic en, input logic mv, input int ch, input int buy,
                         input int sell, input logic cv, input int cc,
                         input logic ev, input rec_t e);
    vec_t v;
    v.en = en; v.mv = mv; v.ch = ch[CH_W-1:0];
    v.buy = buy[PRICE_W-1:0]; v.sell = sell[PRICE_W-1:0];
    v.cv = cv; v.cc = cc[CH_W-1:0]; v.ev = ev; v.e = e;
    tbl.push_back(v);
  endtask

  // Reference model helpers
  function automatic int floor_avg(input int s);
    if (s >= 0) return s / DEPTH;
    return -((-s + DEPTH - 1) / DEPTH);
  endfunction

  task automatic mdl_clear(input int c);
    win_q[c].delete();
    mdl_empty[c] = 1'b1;
  endtask

  task automatic mdl_insert(input int c, input int sp);
    int s;
    if (mdl_empty[c]) begin
      mdl_min[c] = sp;
      mdl_max[c] = sp;
    end else begin
      if (sp < mdl_min[c]) mdl_min[c] = sp;
      if (sp > mdl_max[c]) mdl_max[c] = sp;
    end
    mdl_empty[c] = 1'b0;
    win_q[c].push_back(sp);
    if (win_q[c].size() > DEPTH) void'(win_q[c].pop_front());
    s = 0;
    foreach (win_q[c][k]) s += win_q[c][k];
    exp_q.push_back(mk(c, sp, mdl_min[c], mdl_max[c], floor_avg(s),
                       win_q[c].size() == DEPTH));
  endtask

  initial begin
    rec_t none;
    rec_t r;
    bit   pend_v;
    int   pend_ch;
    int   pend_sp;
    logic en, mv, cv;
    int   ch, buy, sell, cc;

    checks = 0;
    errors = 0;
    reset  = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0);
    none = mk(0, 0, 0, 0, 0, 0);

    // Reset state
    #2;
    check_zero("reset");
    apply_reset();

    // Directed table: expected record is the one visible after this row's edge
    add_row(1, 1, 1, 100,  90, 0, 0, 0, none);
    add_row(1, 1, 0,  50,  80, 0, 0, 1, mk(1,  10,  10,  10,  1, 0));
    add_row(1, 1, 2, 108, 100, 0, 0, 1, mk(0, -30, -30, -30, -4, 0));
    for (int k = 1; k <= 7; k++)
      add_row(1, 1, 2, 108, 100, 0, 0, 1, mk(2, 8, 8, 8, k, 0));
    add_row(1, 1, 2, 116, 100, 0, 0, 1, mk(2,   8,   8,   8,  8, 1));
    add_row(0, 1, 3, 200,   0, 0, 0, 1, mk(2,  16,   8,  16,  9, 1));
    add_row(1, 1, 3,  15,  10, 0, 0, 0, none);
    add_row(1, 1, 3,  17,  10, 0, 0, 1, mk(3,   5,   5,   5,  0, 0));
    add_row(1, 0, 0,   0,   0, 0, 0, 1, mk(3,   7,   5,   7,  1, 0));
    add_row(1, 1, 0,  20,  10, 0, 0, 0, none);
    add_row(1, 1, 0,  20,  10, 0, 0, 1, mk(0,  10, -30,  10, -3, 0));
    add_row(1, 1, 0,  30,  10, 0, 0, 1, mk(0,  10, -30,  10, -2, 0));
    add_row(1, 0, 0,   0,   0, 1, 0, 1, mk(0,  20,  20,  20,  2, 0));
    add_row(1, 1, 0,  14,  10, 0, 0, 0, none);
    add_row(1, 0, 0,   0,   0, 1, 3, 1, mk(0,   4,   4,  20,  3, 0));
    add_row(1, 1, 3,  16,  10, 0, 0, 0, none);
    add_row(1, 1, 1, 255,   0, 0, 0, 1, mk(3,   6,   6,   6,  0, 0));
    add_row(1, 1, 1,   0, 255, 0, 0, 1, mk(1, 255,  10, 255, 33, 0));
    add_row(1, 0, 0,   0,   0, 0, 0, 1, mk(1, -255, -255, 255, 1, 0));

    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      drive(tbl[i].en, tbl[i].mv, int'(tbl[i].ch), int'(tbl[i].buy), int'(tbl[i].sell),
            tbl[i].cv, int'(tbl[i].cc));
      @(posedge clk);
      #1;
      if (tbl[i].ev) check_rec($sformatf("row%0d", i), tbl[i].e);
      else chk($sformatf("row%0d.valid", i), int'(bus.out_valid), 0);
    end

    // Reset asserted between stage 1 and stage 2 of a pending match
    apply_reset();
    @(negedge clk);
    drive(1, 1, 1, 100, 90, 0, 0);
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    check_zero("mid_reset");
    @(negedge clk);
    reset = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      check_zero($sformatf("post_reset%0d", k));
    end
    @(negedge clk);
    drive(1, 1, 1, 5, 10, 0, 0);
    @(posedge clk);
    #1;
    chk("first_after_reset.stage1", int'(bus.out_valid), 0);
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    check_rec("first_after_reset", mk(1, -5, -5, -5, -1, 0));

    // Randomized traffic against the reference model
    apply_reset();
    for (int c = 0; c < CH; c++) mdl_clear(c);
    exp_q.delete();
    pend_v = 1'b0;
    pend_ch = 0;
    pend_sp = 0;
    for (int n = 0; n < 800; n++) begin
      @(negedge clk);
      en   = ($urandom_range(0, 9) != 0);
      mv   = ($urandom_range(0, 3) != 0);
      ch   = int'($urandom_range(0, CH - 1));
      buy  = ($urandom_range(0, 15) == 0) ? 255 : int'($urandom_range(0, 255));
      sell = ($urandom_range(0, 15) == 0) ? 255 : int'($urandom_range(0, 255));
      cv   = ($urandom_range(0, 11) == 0);
      cc   = int'($urandom_range(0, CH - 1));
      drive(en, mv, ch, buy, sell, cv, cc);
      @(posedge clk);
      if (cv) mdl_clear(cc);
      if (pend_v) mdl_insert(pend_ch, pend_sp);
      pend_v  = mv && en;
      pend_ch = ch;
      pend_sp = buy - sell;
      #1;
      if (exp_q.size() > 0) begin
        r = rec_t'(exp_q.pop_front());
        check_rec($sformatf("rnd%0d", n), r);
      end else begin
        chk($sformatf("rnd%0d.valid", n), int'(bus.out_valid), 0);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
